// File: rtl/pattern_serializer.sv
// Parallel-to-serial front end: one-word holding buffer ahead of an MSB-first shifter,
// producing a gap-free bit stream with per-bit valid and word frame markers.
module pattern_serializer #(
    parameter int   WIDTH    = 9,
    parameter logic IDLE_BIT = 1'b0,
    parameter int   CNT_W    = 16
) (
    input  logic             clock,
    input  logic             res_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic [CNT_W-1:0] words_sent
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   words_q, words_d;

    logic accept;
    logic last_bit;

    // Accept and drain are mutually exclusive: accept needs an empty hold, drain a full one.
    assign accept   = data_valid && !hold_full_q;
    assign last_bit = (cnt_q == LAST_BIT);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        words_d     = words_q;

        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + BIT_W'(1);
                if (last_bit) begin
                    words_d = words_q + CNT_W'(1);
                    cnt_d   = '0;
                    // A held word follows the LSB directly, keeping the stream gap-free.
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge res_n) begin
        if (!res_n) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            words_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            words_q     <= words_d;
        end
    end

    // Outputs decode registered state only; no path from data_valid or data_in.
    assign data_ready   = !hold_full_q;
    assign serial_valid = (state_q == S_SHIFT);
    assign serial       = serial_valid ? shift_q[WIDTH-1] : IDLE_BIT;
    assign frame_start  = serial_valid && (cnt_q == '0);
    assign frame_end    = serial_valid && last_bit;
    assign words_sent   = words_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer: directed vectors, corner sequences and
// randomized traffic compared against a queue-based bit-stream model.
module tb_pattern_serializer;

    localparam int W = 9;

    logic         clock = 1'b0;
    logic         res_n;
    logic [W-1:0] data_in;
    logic         data_valid;
    logic         data_ready, serial, serial_valid, frame_start, frame_end;
    logic [15:0]  words_sent;
    logic         data_ready2, serial2, serial_valid2, frame_start2, frame_end2;
    logic [1:0]   words_sent2;

    int n_tests = 0;
    int n_fail  = 0;

    pattern_serializer #(.WIDTH(W), .IDLE_BIT(1'b0), .CNT_W(16)) dut (
        .clock(clock), .res_n(res_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .serial(serial), .serial_valid(serial_valid),
        .frame_start(frame_start), .frame_end(frame_end), .words_sent(words_sent)
    );

    pattern_serializer #(.WIDTH(W), .IDLE_BIT(1'b0), .CNT_W(2)) dut_wrap (
        .clock(clock), .res_n(res_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready2), .serial(serial2), .serial_valid(serial_valid2),
        .frame_start(frame_start2), .frame_end(frame_end2), .words_sent(words_sent2)
    );

    always #5 clock = ~clock;

    // Reference model: the words the producer handed over, expressed as a queue of bits.
    logic [W-1:0] m_hold;
    bit           m_hold_full;
    bit           m_bits[$];
    int unsigned  m_words;
    logic [W-1:0] acc_q[$];
    logic [W-1:0] out_q[$];
    logic [W-1:0] asm_word;
    int           valid_total, cur_run, max_run;

    typedef struct {
        logic         dv;
        logic [W-1:0] din;
        logic         e_ready, e_serial, e_valid, e_fs, e_fe;
        logic [15:0]  e_words;
    } vec_t;

    vec_t tbl[11];
    logic [1:0] wrap_exp[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_hold_full = 0;
        m_hold      = '0;
        m_bits.delete();
        m_words     = 0;
        acc_q.delete();
        out_q.delete();
        asm_word    = '0;
    endfunction

    function automatic void model_load();
        for (int i = W - 1; i >= 0; i--) m_bits.push_back(m_hold[i]);
        m_hold_full = 0;
    endfunction

    function automatic void model_step();
        bit acc;
        if (!res_n) begin
            model_reset();
            return;
        end
        acc = data_valid && !m_hold_full;
        if (m_bits.size() > 0) begin
            void'(m_bits.pop_front());
            if (m_bits.size() == 0) begin
                m_words++;
                if (m_hold_full) model_load();
            end
        end else if (m_hold_full) begin
            model_load();
        end
        if (acc) begin
            m_hold      = data_in;
            m_hold_full = 1;
            acc_q.push_back(data_in);
        end
    endfunction

    task automatic compare_all();
        int n;
        n = m_bits.size();
        check("serial",       serial,       (n > 0) ? m_bits[0] : 1'b0);
        check("serial_valid", serial_valid, n > 0);
        check("frame_start",  frame_start,  n == W);
        check("frame_end",    frame_end,    n == 1);
        check("data_ready",   data_ready,   !m_hold_full);
        check("words_sent",   words_sent,   16'(m_words));
        check("words_sent_wrap", words_sent2, 2'(m_words));
        if (serial_valid) begin
            asm_word = {asm_word[W-2:0], serial};
            if (frame_end) out_q.push_back(asm_word);
            valid_total++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            cur_run = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge, data_valid left high.
    task automatic offer(input logic [W-1:0] w);
        data_in    = w;
        data_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (data_ready) begin
                tick();
                return;
            end
            tick();
        end
        check("offer_timeout", 1, 0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 9'h14D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[6]  = '{1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[7]  = '{1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[8]  = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[9]  = '{1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
        tbl[10] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        data_in = '0; data_valid = 1'b0; res_n = 1'b0;
        model_reset();
        valid_total = 0; cur_run = 0; max_run = 0;

        // Reset and idle.
        #1;
        check("rst_serial_valid", serial_valid, 0);
        check("rst_data_ready",   data_ready,   1);
        check("rst_words_sent",   words_sent,   0);
        repeat (3) tick();
        res_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_serial", serial, 0);
            check("idle_valid",  serial_valid, 0);
            check("idle_ready",  data_ready, 1);
            check("idle_words",  words_sent, 0);
        end

        // Single word, cycle by cycle.
        for (int i = 0; i < 11; i++) begin
            data_valid = tbl[i].dv;
            data_in    = tbl[i].din;
            tick();
            check($sformatf("vec%0d_ready", i),  data_ready,   tbl[i].e_ready);
            check($sformatf("vec%0d_serial", i), serial,       tbl[i].e_serial);
            check($sformatf("vec%0d_valid", i),  serial_valid, tbl[i].e_valid);
            check($sformatf("vec%0d_fs", i),     frame_start,  tbl[i].e_fs);
            check($sformatf("vec%0d_fe", i),     frame_end,    tbl[i].e_fe);
            check($sformatf("vec%0d_words", i),  words_sent,   tbl[i].e_words);
        end

        // Back-to-back: three words must form one 27-bit run.
        valid_total = 0; cur_run = 0; max_run = 0;
        offer(9'b101001101);
        offer(9'b010010010);
        offer(9'h1FF);
        data_valid = 1'b0;
        repeat (30) tick();
        check("b2b_valid_bits", valid_total, 27);
        check("b2b_longest_run", max_run, 27);
        check("b2b_words_sent", words_sent, 4);

        // Backpressure: data_valid mostly high, data changing every cycle.
        for (int i = 0; i < 3000; i++) begin
            data_valid = ($urandom_range(0, 3) != 0);
            data_in    = W'($urandom);
            tick();
        end
        data_valid = 1'b0;
        repeat (30) tick();
        check("stream_word_count", out_q.size(), acc_q.size());
        for (int i = 0; i < acc_q.size() && i < out_q.size(); i++)
            check($sformatf("stream_word%0d", i), out_q[i], acc_q[i]);

        // Reset during bit 4 of a word, with a second word held.
        offer(9'h0F3);
        offer(9'h1A5);
        data_valid = 1'b0;
        tick();
        tick();
        check("pre_reset_valid", serial_valid, 1);
        check("pre_reset_ready", data_ready, 0);
        #2 res_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_serial", serial, 0);
        check("async_rst_valid",  serial_valid, 0);
        check("async_rst_fs",     frame_start, 0);
        check("async_rst_fe",     frame_end, 0);
        check("async_rst_ready",  data_ready, 1);
        check("async_rst_words",  words_sent, 0);
        tick();
        tick();
        res_n = 1'b1;
        valid_total = 0;
        repeat (15) tick();
        check("post_reset_no_bits", valid_total, 0);
        check("post_reset_words",   words_sent, 0);

        // Counter wrap on the CNT_W=2 instance.
        for (int i = 0; i < 5; i++) begin
            offer(W'($urandom));
            data_valid = 1'b0;
            repeat (11) tick();
            check($sformatf("wrap_word%0d", i), words_sent2, wrap_exp[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
